// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC register, keeps one instruction-memory fetch
// outstanding, buffers one instruction toward decode and squashes stale responses.
module fetch_sequencer #(
    parameter int DATA        = 32,
    parameter int INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DATA-1:0] pc,
    output logic [DATA-1:0] pc_next,
    output logic            pc_stall,
    output logic            imem_req,
    output logic [DATA-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [DATA-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [DATA-1:0] redirect_target,
    input  logic            pipe_stall,
    output logic            instr_valid,
    output logic [DATA-1:0] instr,
    output logic [DATA-1:0] instr_pc
);

    // state | meaning
    // REQ   | request presented, not yet granted
    // WAIT  | one request outstanding on the current path
    // DRAIN | outstanding response belongs to a stale path, drop it
    localparam logic [1:0] REQ   = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            capture;
    logic            buf_busy;
    logic [DATA-1:0] redirect_pc;

    assign buf_busy    = instr_valid && pipe_stall;
    // Targets are forced onto an instruction-word boundary.
    assign redirect_pc = redirect_target & ~DATA'(3);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        pc_stall  = 1'b1;
        pc_next   = pc + DATA'(INSTR_BYTES);
        imem_req  = 1'b0;
        imem_addr = pc;

        case (state)
            REQ: begin
                imem_req = !buf_busy && !redirect_valid;
                if (imem_req && imem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    capture   = 1'b1;
                    pc_stall  = 1'b0;
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = REQ;
            end
        endcase

        // A redirect wins over everything; a response still in flight is stale.
        if (redirect_valid) begin
            capture  = 1'b0;
            pc_stall = 1'b0;
            pc_next  = redirect_pc;
            if (state == REQ) begin
                state_nxt = REQ;
            end else if (imem_rvalid) begin
                state_nxt = REQ;
            end else begin
                state_nxt = DRAIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= REQ;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid) begin
                instr_valid <= 1'b0;
            end else if (capture) begin
                instr_valid <= 1'b1;
                instr       <= imem_rdata;
                instr_pc    <= pc;
            end else if (!pipe_stall) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
